// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect sequencer around the execute stage.
// Inserts load-use bubbles, applies branch/jump redirects (deferring them
// while the memory stage holds the pipe), and keeps stall/flush counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal issue; a load-use hazard inserts a bubble
// LOAD_WAIT  | extra load-use bubbles; the cycle with cnt==0 behaves as RUN
// FLUSH      | fetch/decode flushed after a redirect, execute sees bubbles
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic        ex_run,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_re,
  input  logic        ex_addr_en,
  input  logic [31:0] ex_addr,
  input  logic        mem_busy,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_exec,
  output logic        exec_run,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH     = 2'd2;

  localparam logic [2:0] LOAD_CNT_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_CNT_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        flush_q, flush_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  logic haz;
  logic redir;
  logic run_like;
  logic load_hold;
  logic stall_fd_c;
  logic stall_ex_c;
  logic exec_run_c;

  // Hazard detection and stall/run qualifiers for the current cycle
  always_comb begin
    haz = dec_valid & ex_run & ex_re & ex_reg_we & (ex_rd != 5'd0) &
          ((dec_rs1_used & (dec_rs1 == ex_rd)) |
           (dec_rs2_used & (dec_rs2 == ex_rd)));
    redir     = ex_addr_en | pend_valid_q;
    // The last LOAD_WAIT count acts as RUN so the total bubble count
    // equals LOAD_STALL_CYCLES including the detection cycle.
    run_like  = (state_q == ST_RUN) | ((state_q == ST_LOAD_WAIT) & (cnt_q == 3'd0));
    load_hold = (state_q == ST_LOAD_WAIT) & (cnt_q != 3'd0);

    stall_fd_c = 1'b0;
    stall_ex_c = 1'b0;
    exec_run_c = dec_valid;
    if (!reset) begin
      if (mem_busy) begin
        stall_fd_c = 1'b1;
        stall_ex_c = 1'b1;
        exec_run_c = dec_valid & ~(state_q == ST_FLUSH) & ~load_hold;
      end else if (state_q == ST_FLUSH) begin
        exec_run_c = 1'b0;
      end else if (load_hold) begin
        stall_fd_c = 1'b1;
        exec_run_c = 1'b0;
      end else if (run_like & haz & ~redir) begin
        stall_fd_c = 1'b1;
        exec_run_c = 1'b0;
      end
    end
  end

  // Next-state: mem_busy freezes, redirect beats hazard, then FSM stepping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target_q;
    flush_count_d = flush_count_q;

    if (mem_busy) begin
      if (ex_addr_en) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = ex_addr;
      end
    end else if (redir) begin
      pc_load_d     = 1'b1;
      pc_target_d   = ex_addr_en ? ex_addr : pend_addr_q;
      pend_valid_d  = 1'b0;
      state_d       = ST_FLUSH;
      cnt_d         = FLUSH_CNT_INIT;
      flush_count_d = flush_count_q + 32'd1;
    end else begin
      case (state_q)
        ST_RUN, ST_LOAD_WAIT: begin
          if (load_hold) begin
            cnt_d = cnt_q - 3'd1;
          end else if (haz) begin
            state_d = ST_LOAD_WAIT;
            cnt_d   = LOAD_CNT_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end

    flush_d       = (state_d == ST_FLUSH);
    stall_count_d = stall_count_q + {31'd0, stall_fd_c};
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= 32'd0;
      pc_load_q     <= 1'b0;
      pc_target_q   <= 32'd0;
      flush_q       <= 1'b0;
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      pc_load_q     <= pc_load_d;
      pc_target_q   <= pc_target_d;
      flush_q       <= flush_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_fetch  = stall_fd_c;
  assign stall_decode = stall_fd_c;
  assign stall_exec   = stall_ex_c;
  assign exec_run     = exec_run_c;
  assign flush_fetch  = flush_q;
  assign flush_decode = flush_q;
  assign pc_load      = pc_load_q;
  assign pc_target    = pc_target_q;
  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default instance (1 load bubble,
// 2 flush cycles) plus a 3-bubble instance for the reset-in-LOAD_WAIT case.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        dec_rs1_used, dec_rs2_used;
  logic        ex_run;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_re, ex_addr_en;
  logic [31:0] ex_addr;
  logic        mem_busy;

  logic        stall_fetch, stall_decode, stall_exec, exec_run;
  logic        flush_fetch, flush_decode, pc_load;
  logic [31:0] pc_target, stall_count, flush_count;

  logic        u3_stall_fetch, u3_stall_decode, u3_stall_exec, u3_exec_run;
  logic        u3_flush_fetch, u3_flush_decode, u3_pc_load;
  logic [31:0] u3_pc_target, u3_stall_count, u3_flush_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .ex_run(ex_run), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_re(ex_re), .ex_addr_en(ex_addr_en), .ex_addr(ex_addr),
    .mem_busy(mem_busy), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .stall_exec(stall_exec), .exec_run(exec_run), .flush_fetch(flush_fetch),
    .flush_decode(flush_decode), .pc_load(pc_load), .pc_target(pc_target),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut3 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .ex_run(ex_run), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_re(ex_re), .ex_addr_en(ex_addr_en), .ex_addr(ex_addr),
    .mem_busy(mem_busy), .stall_fetch(u3_stall_fetch), .stall_decode(u3_stall_decode),
    .stall_exec(u3_stall_exec), .exec_run(u3_exec_run), .flush_fetch(u3_flush_fetch),
    .flush_decode(u3_flush_decode), .pc_load(u3_pc_load), .pc_target(u3_pc_target),
    .stall_count(u3_stall_count), .flush_count(u3_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b1; dec_rs1 = 5'd1; dec_rs2 = 5'd2;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    ex_run = 1'b0; ex_rd = 5'd0; ex_reg_we = 1'b0; ex_re = 1'b0;
    ex_addr_en = 1'b0; ex_addr = 32'd0; mem_busy = 1'b0;
  endtask

  // load x5 in EX, decode reads x5 through rs1
  task automatic load_use();
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs1_used = 1'b1;
    ex_run = 1'b1; ex_rd = 5'd5; ex_reg_we = 1'b1; ex_re = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    mem_busy = 1'b1;
    tick(); #1;
    chk("rst_stall_fetch", {31'd0, stall_fetch}, 32'd0);
    chk("rst_stall_exec", {31'd0, stall_exec}, 32'd0);
    chk("rst_exec_run", {31'd0, exec_run}, 32'd1);
    tick(); reset = 1'b0; idle(); #1;
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_flush", {31'd0, flush_fetch}, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    chk("rst_flush_count", flush_count, 32'd0);
    chk("rst_stall_decode", {31'd0, stall_decode}, 32'd0);

    // load-use hazard: one bubble cycle
    tick(); load_use(); #1;
    chk("haz_stall_decode", {31'd0, stall_decode}, 32'd1);
    chk("haz_stall_fetch", {31'd0, stall_fetch}, 32'd1);
    chk("haz_stall_exec", {31'd0, stall_exec}, 32'd0);
    chk("haz_exec_run", {31'd0, exec_run}, 32'd0);
    tick(); ex_run = 1'b0; #1;
    chk("haz_done_stall", {31'd0, stall_decode}, 32'd0);
    chk("haz_done_run", {31'd0, exec_run}, 32'd1);
    chk("haz_stall_count", stall_count, 32'd1);
    tick(); load_use(); ex_rd = 5'd0; dec_rs1 = 5'd0; #1;
    chk("x0_no_stall", {31'd0, stall_decode}, 32'd0);

    // single redirect to 0x100
    tick(); idle(); ex_addr_en = 1'b1; ex_addr = 32'h100; #1;
    chk("redir_pc_load_now", {31'd0, pc_load}, 32'd0);
    tick(); idle(); #1;
    chk("redir_pc_load", {31'd0, pc_load}, 32'd1);
    chk("redir_pc_target", pc_target, 32'h100);
    chk("redir_flush_f1", {31'd0, flush_fetch}, 32'd1);
    chk("redir_flush_d1", {31'd0, flush_decode}, 32'd1);
    chk("redir_exec_run1", {31'd0, exec_run}, 32'd0);
    chk("redir_flush_count", flush_count, 32'd1);
    tick(); #1;
    chk("redir_pc_load_off", {31'd0, pc_load}, 32'd0);
    chk("redir_flush_f2", {31'd0, flush_fetch}, 32'd1);
    chk("redir_exec_run2", {31'd0, exec_run}, 32'd0);
    tick(); #1;
    chk("redir_flush_end", {31'd0, flush_fetch}, 32'd0);
    chk("redir_run_back", {31'd0, exec_run}, 32'd1);

    // redirect while memory stage busy for 3 cycles
    tick(); mem_busy = 1'b1; ex_addr_en = 1'b1; ex_addr = 32'h400; #1;
    chk("busy_stall_fetch", {31'd0, stall_fetch}, 32'd1);
    chk("busy_stall_decode", {31'd0, stall_decode}, 32'd1);
    chk("busy_stall_exec", {31'd0, stall_exec}, 32'd1);
    tick(); ex_addr_en = 1'b0; #1;
    chk("busy_pc_load1", {31'd0, pc_load}, 32'd0);
    tick(); #1;
    chk("busy_pc_load2", {31'd0, pc_load}, 32'd0);
    tick(); mem_busy = 1'b0; #1;
    chk("busy_pc_load3", {31'd0, pc_load}, 32'd0);
    chk("busy_stall_count", stall_count, 32'd4);
    chk("busy_released", {31'd0, stall_decode}, 32'd0);
    tick(); #1;
    chk("pend_pc_load", {31'd0, pc_load}, 32'd1);
    chk("pend_pc_target", pc_target, 32'h400);
    chk("pend_flush_count", flush_count, 32'd2);
    tick(); #1;
    tick(); #1;
    chk("pend_flush_end", {31'd0, flush_fetch}, 32'd0);

    // hazard and redirect in the same cycle: redirect wins
    tick(); load_use(); ex_addr_en = 1'b1; ex_addr = 32'h500; #1;
    chk("both_no_stall", {31'd0, stall_decode}, 32'd0);
    tick(); idle(); #1;
    chk("both_pc_target", pc_target, 32'h500);
    chk("both_exec_run1", {31'd0, exec_run}, 32'd0);
    chk("both_no_loadwait", {31'd0, stall_decode}, 32'd0);
    tick(); #1;
    chk("both_exec_run2", {31'd0, exec_run}, 32'd0);
    tick(); #1;
    chk("both_exec_run3", {31'd0, exec_run}, 32'd1);
    chk("both_stall_count", stall_count, 32'd4);
    chk("both_flush_count", flush_count, 32'd3);

    // second redirect during FLUSH
    tick(); ex_addr_en = 1'b1; ex_addr = 32'h200; #1;
    tick(); ex_addr = 32'h300; #1;
    chk("dbl_pc_load1", {31'd0, pc_load}, 32'd1);
    chk("dbl_target1", pc_target, 32'h200);
    tick(); idle(); #1;
    chk("dbl_pc_load2", {31'd0, pc_load}, 32'd1);
    chk("dbl_target2", pc_target, 32'h300);
    chk("dbl_flush_a", {31'd0, flush_fetch}, 32'd1);
    tick(); #1;
    chk("dbl_pc_load_off", {31'd0, pc_load}, 32'd0);
    chk("dbl_flush_b", {31'd0, flush_decode}, 32'd1);
    tick(); #1;
    chk("dbl_flush_end", {31'd0, flush_fetch}, 32'd0);
    chk("dbl_flush_count", flush_count, 32'd5);

    // 3-bubble instance: reset while in LOAD_WAIT
    tick(); reset = 1'b1; idle(); #1;
    tick(); reset = 1'b0; #1;
    tick(); load_use(); #1;
    chk("lw3_stall0", {31'd0, u3_stall_decode}, 32'd1);
    chk("lw3_exec_run0", {31'd0, u3_exec_run}, 32'd0);
    tick(); ex_run = 1'b0; #1;
    chk("lw3_stall1", {31'd0, u3_stall_decode}, 32'd1);
    chk("lw3_exec_run1", {31'd0, u3_exec_run}, 32'd0);
    chk("lw3_stall_count", u3_stall_count, 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0; idle(); #1;
    chk("lw3_rst_stall_decode", {31'd0, u3_stall_decode}, 32'd0);
    chk("lw3_rst_stall_fetch", {31'd0, u3_stall_fetch}, 32'd0);
    chk("lw3_rst_stall_exec", {31'd0, u3_stall_exec}, 32'd0);
    chk("lw3_rst_exec_run", {31'd0, u3_exec_run}, 32'd1);
    chk("lw3_rst_stall_count", u3_stall_count, 32'd0);
    chk("lw3_rst_flush_count", u3_flush_count, 32'd0);
    tick(); load_use(); #1;
    chk("lw3_run_haz", {31'd0, u3_stall_decode}, 32'd1);
    tick(); idle(); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
